// File: rtl/inst_fetch_unit.sv
//==============================================================================
// Module      : inst_fetch_unit
// Description : MIPS F-stage instruction fetch front end. Holds pcF, issues
//               one request at a time on the instruction-side SRAM-like bus,
//               presents the fetched word to decode with a valid/stall
//               handshake and discards in-flight fetches on a PC redirect.
//               Optional feature macro: FETCH_ADDR_EXC_EN (misaligned pcF
//               raises adelF instead of issuing a request).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallF,
    input  logic        redirectM,
    input  logic [31:0] pc_next,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F,
    output logic [31:0] instrF,
    output logic        instr_validF,
    output logic        adelF
);

    // REQ: request on the bus; WAIT: accepted, data pending;
    // VALID: word presented to decode; CANCEL: pending data will be dropped.
    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_VALID  = 2'd2,
        ST_CANCEL = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        w_pc_misaligned;
    logic        w_accept;

`ifdef FETCH_ADDR_EXC_EN
    logic        r_adel;

    // A misaligned PC is never put on the bus; it traps to an address error.
    assign w_pc_misaligned = |r_pc[1:0];
    assign adelF           = r_adel;
`else
    // Without the exception feature a misaligned PC is issued unchanged.
    assign w_pc_misaligned = 1'b0;
    assign adelF           = 1'b0;
`endif

    // Bus request is decoded from registered state only.
    assign inst_req  = (r_state == ST_REQ) && !w_pc_misaligned;
    assign inst_addr = r_pc;
    assign w_accept  = inst_req && inst_addr_ok;

    assign pcF          = r_pc;
    assign pcplus4F     = r_pc + 32'd4;
    assign instrF       = r_instr;
    assign instr_validF = r_valid;

    // Fetch state machine with registered PC, instruction and flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_REQ;
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
`ifdef FETCH_ADDR_EXC_EN
            r_adel  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_REQ: begin
`ifdef FETCH_ADDR_EXC_EN
                    // A redirect overrides the trap: the misaligned PC was on
                    // the wrong path.
                    if (w_pc_misaligned && !redirectM) begin
                        r_instr <= 32'd0;
                        r_adel  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_VALID;
                    end else
`endif
                    if (w_accept) begin
                        if (redirectM) begin
                            // Old address already accepted: drop its data.
                            r_pc    <= pc_next;
                            r_state <= ST_CANCEL;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else if (redirectM) begin
                        r_pc <= pc_next;
                    end
                end

                ST_WAIT: begin
                    if (inst_data_ok) begin
                        if (redirectM) begin
                            r_pc    <= pc_next;
                            r_state <= ST_REQ;
                        end else begin
                            r_instr <= inst_rdata;
                            r_valid <= 1'b1;
                            r_state <= ST_VALID;
                        end
                    end else if (redirectM) begin
                        r_pc    <= pc_next;
                        r_state <= ST_CANCEL;
                    end
                end

                ST_VALID: begin
                    // Redirect wins over a decode stall.
                    if (redirectM || !stallF) begin
                        r_valid <= 1'b0;
                        r_pc    <= pc_next;
`ifdef FETCH_ADDR_EXC_EN
                        r_adel  <= 1'b0;
`endif
                        r_state <= ST_REQ;
                    end
                end

                ST_CANCEL: begin
                    if (redirectM) begin
                        r_pc <= pc_next;
                    end
                    if (inst_data_ok) begin
                        r_state <= ST_REQ;
                    end
                end

                default: begin
                    r_state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
//==============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit. Directed scenarios
//               followed by randomized traffic against a transaction-level
//               reference model and a variable-latency memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'hBFC00000;
`ifdef FETCH_ADDR_EXC_EN
    localparam bit C_EXC = 1'b1;
`else
    localparam bit C_EXC = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        stallF;
    logic        redirectM;
    logic [31:0] pc_next;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;
    logic [31:0] instrF;
    logic        instr_validF;
    logic        adelF;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: presented instruction plus one outstanding transaction
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_adel;
    bit          m_out;      // an accepted request has not yet returned data
    bit          m_disc;     // that outstanding data must be thrown away

    // Memory model
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_word;

    inst_fetch_unit #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .stallF       (stallF),
        .redirectM    (redirectM),
        .pc_next      (pc_next),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .pcF          (pcF),
        .pcplus4F     (pcplus4F),
        .instrF       (instrF),
        .instr_validF (instr_validF),
        .adelF        (adelF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit exp_req();
        return !m_valid && !m_out && !(C_EXC && (m_pc[1:0] != 2'b00));
    endfunction

    function automatic bit m_idle();
        return !m_valid && !m_out;
    endfunction

    task automatic model_reset();
        m_pc     = C_RESET_PC;
        m_instr  = 32'd0;
        m_valid  = 1'b0;
        m_adel   = 1'b0;
        m_out    = 1'b0;
        m_disc   = 1'b0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_word = 32'd0;
    endtask

    // Called just after a falling edge: check outputs, drive inputs, advance
    // the model by one clock, then wait for the next falling edge.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] tgt,
                         input bit aok, input int lat, input logic [31:0] word,
                         input bit spur);
        bit          req_e;
        bit          aok_d;
        bit          dok_d;
        logic [31:0] nxt;
        logic [31:0] rd;
        req_e = exp_req();
        check("pcF",          pcF,                    m_pc);
        check("pcplus4F",     pcplus4F,               m_pc + 32'd4);
        check("inst_req",     {31'd0, inst_req},      {31'd0, req_e});
        check("inst_addr",    inst_addr,              m_pc);
        check("instr_validF", {31'd0, instr_validF},  {31'd0, m_valid});
        check("instrF",       instrF,                 m_instr);
        check("adelF",        {31'd0, adelF},         {31'd0, m_adel});

        nxt   = redir ? tgt : m_pc + 32'd4;
        aok_d = aok && req_e;
        dok_d = (mem_busy && mem_cnt == 0) || (spur && !mem_busy);
        rd    = mem_busy ? mem_word : $urandom;
        stallF       = stall;
        redirectM    = redir;
        pc_next      = nxt;
        inst_addr_ok = aok_d;
        inst_data_ok = dok_d;
        inst_rdata   = rd;

        if (m_valid) begin
            if (redir || !stall) begin
                m_valid = 1'b0;
                m_adel  = 1'b0;
                m_pc    = nxt;
            end
        end else if (m_out) begin
            if (dok_d) begin
                if (!m_disc && !redir) begin
                    m_valid = 1'b1;
                    m_instr = rd;
                end
                if (redir) m_pc = nxt;
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (redir) begin
                m_pc   = nxt;
                m_disc = 1'b1;
            end
        end else begin
            if (C_EXC && (m_pc[1:0] != 2'b00) && !redir) begin
                m_valid = 1'b1;
                m_instr = 32'd0;
                m_adel  = 1'b1;
            end else begin
                if (aok_d) begin
                    m_out  = 1'b1;
                    m_disc = redir;
                end
                if (redir) m_pc = nxt;
            end
        end

        if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (aok_d) begin
            mem_busy = 1'b1;
            mem_cnt  = lat;
            mem_word = word;
        end

        @(negedge clk);
    endtask

    initial begin
        resetn       = 1'b0;
        stallF       = 1'b0;
        redirectM    = 1'b0;
        pc_next      = 32'd0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_pcF",   pcF,                   C_RESET_PC);
        check("rst_valid", {31'd0, instr_validF}, 32'd0);
        check("rst_instr", instrF,                32'd0);
        resetn = 1'b1;

        // Zero-wait fetch right after reset release
        check("first_req",  {31'd0, inst_req}, 32'd1);
        check("first_addr", inst_addr,         32'hBFC00000);
        cycle(0, 0, 32'd0, 1, 0, 32'h24080001, 0);
        cycle(1, 0, 32'd0, 0, 0, 32'd0, 0);
        check("zw_valid", {31'd0, instr_validF}, 32'd1);
        check("zw_instr", instrF,                32'h24080001);

        // Decode stall holds the presented instruction
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 32'd0, 0, 0, 32'd0, 0);
            check("stall_instr", instrF, 32'h24080001);
            check("stall_pc",    pcF,    32'hBFC00000);
        end
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        check("after_stall_addr", inst_addr, 32'hBFC00004);

        // Redirect while waiting; late word must be discarded
        cycle(0, 0, 32'd0, 1, 2, 32'hDEADBEEF, 0);
        cycle(0, 1, 32'hBFC00100, 0, 0, 32'd0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
            check("cancel_valid", {31'd0, instr_validF}, 32'd0);
        end
        check("redir_req",  {31'd0, inst_req}, 32'd1);
        check("redir_addr", inst_addr,         32'hBFC00100);

        // Redirect together with address acceptance
        cycle(0, 1, 32'hBFC00200, 1, 1, 32'h11111111, 0);
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        check("rq_cancel_addr",  inst_addr,             32'hBFC00200);
        check("rq_cancel_valid", {31'd0, instr_validF}, 32'd0);
        cycle(0, 0, 32'd0, 1, 0, 32'h22222222, 0);
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        check("rq_new_instr", instrF, 32'h22222222);
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
            cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 15, tgt,
                  $urandom_range(0, 99) < 60, int'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, 99) < 10);
        end

        // Drain to an idle, aligned REQ, then enter WAIT and pulse reset
        for (int i = 0; i < 12; i++) begin
            if (m_idle()) break;
            cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        end
        cycle(0, 1, 32'hBFC00400, 0, 0, 32'd0, 0);
        cycle(0, 0, 32'd0, 1, 3, 32'h44444444, 0);
        resetn       = 1'b0;
        stallF       = 1'b0;
        redirectM    = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #1;
        model_reset();
        check("arst_pcF",   pcF,                   C_RESET_PC);
        check("arst_valid", {31'd0, instr_validF}, 32'd0);
        check("arst_instr", instrF,                32'd0);
        check("arst_adel",  {31'd0, adelF},        32'd0);
        check("arst_req",   {31'd0, inst_req},     32'd1);
        @(negedge clk);
        resetn = 1'b1;
        check("restart_addr", inst_addr, C_RESET_PC);
        cycle(0, 0, 32'd0, 1, 0, 32'h33333333, 0);
        cycle(1, 0, 32'd0, 0, 0, 32'd0, 0);
        check("restart_instr", instrF, 32'h33333333);

`ifdef FETCH_ADDR_EXC_EN
        // Misaligned redirect target traps instead of fetching
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);
        cycle(0, 1, 32'hBFC00102, 0, 0, 32'd0, 0);
        check("adel_noreq", {31'd0, inst_req}, 32'd0);
        cycle(0, 0, 32'd0, 1, 0, 32'h55555555, 0);
        check("adel_flag",  {31'd0, adelF},        32'd1);
        check("adel_instr", instrF,                32'd0);
        check("adel_valid", {31'd0, instr_validF}, 32'd1);
        cycle(0, 1, 32'hBFC00380, 0, 0, 32'd0, 0);
        check("adel_clear", {31'd0, adelF}, 32'd0);
`endif
        cycle(0, 0, 32'd0, 0, 0, 32'd0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
